// File: rtl/ws2811_frame_sequencer.sv
// Frame sequencer for a WS2811 transmitter: walks a pixel buffer, scales each word
// by a latched brightness, hands it over via start/busy, then holds the latch gap.
module ws2811_frame_sequencer #(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int PIXEL_COUNT = 50,
    parameter int ADDR_WIDTH  = 6,
    parameter int RESET_US    = 60
) (
    input  logic                  clkIN,
    input  logic                  resetIN,
    input  logic                  frameStartIN,
    input  logic [7:0]            brightnessIN,
    output logic                  frameBusyOUT,
    output logic                  frameDoneOUT,
    output logic [ADDR_WIDTH-1:0] pixelAddrOUT,
    input  logic [23:0]           pixelDataIN,
    output logic                  txStartOUT,
    output logic [23:0]           txDataOUT,
    input  logic                  txBusyIN
);

    localparam int GAP_CYCLES = (CLOCK_SPEED / 1_000_000) * RESET_US;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4,
        S_RGAP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                r_state;
    logic [7:0]            r_bright;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic                  r_frame_busy;
    logic                  r_frame_done;
    logic                  r_tx_start;
    logic [23:0]           r_tx_data;

    // (c * (b + 1)) >> 8 on a 16-bit product; b = 255 passes c through unchanged.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
    endfunction

    function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
        return {scale_byte(w[23:16], b), scale_byte(w[15:8], b), scale_byte(w[7:0], b)};
    endfunction

    // Frame sequencing FSM with registered outputs.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            r_state      <= S_IDLE;
            r_bright     <= 8'd0;
            r_index      <= '0;
            r_gap_cnt    <= '0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 24'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frameStartIN) begin
                        r_bright     <= brightnessIN;
                        r_index      <= '0;
                        r_frame_busy <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                // The address is already on the RAM port; this cycle covers its read latency.
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_tx_data  <= scale_word(pixelDataIN, r_bright);
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (txBusyIN) begin
                        r_tx_start <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!txBusyIN) begin
                        if (r_index == LAST_IDX) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_RGAP;
                        end else begin
                            r_index <= r_index + ADDR_WIDTH'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_RGAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_frame_done <= 1'b1;
                        r_frame_busy <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_bright     <= 8'd0;
                    r_index      <= '0;
                    r_gap_cnt    <= '0;
                    r_frame_busy <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_tx_start   <= 1'b0;
                    r_tx_data    <= 24'd0;
                end
            endcase
        end
    end

    assign frameBusyOUT = r_frame_busy;
    assign frameDoneOUT = r_frame_done;
    assign pixelAddrOUT = r_index;
    // Start is gated by reset so a mid-frame reset withdraws the request in the same cycle.
    assign txStartOUT   = r_tx_start & ~resetIN;
    assign txDataOUT    = r_tx_data;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Directed, table-driven bench for ws2811_frame_sequencer with a RAM model
// and a transmitter model whose busy delay and length are adjustable.
module tb_ws2811_frame_sequencer;

    localparam int PC  = 3;
    localparam int AW  = 6;
    localparam int GAP = 3000;

    logic          clkIN = 1'b0;
    logic          resetIN;
    logic          frameStartIN;
    logic [7:0]    brightnessIN;
    logic          frameBusyOUT;
    logic          frameDoneOUT;
    logic [AW-1:0] pixelAddrOUT;
    logic [23:0]   pixelDataIN;
    logic          txStartOUT;
    logic [23:0]   txDataOUT;
    logic          txBusyIN;

    always #5 clkIN = ~clkIN;

    ws2811_frame_sequencer #(
        .CLOCK_SPEED(50_000_000), .PIXEL_COUNT(PC), .ADDR_WIDTH(AW), .RESET_US(60)
    ) dut (
        .clkIN(clkIN), .resetIN(resetIN), .frameStartIN(frameStartIN),
        .brightnessIN(brightnessIN), .frameBusyOUT(frameBusyOUT), .frameDoneOUT(frameDoneOUT),
        .pixelAddrOUT(pixelAddrOUT), .pixelDataIN(pixelDataIN), .txStartOUT(txStartOUT),
        .txDataOUT(txDataOUT), .txBusyIN(txBusyIN)
    );

    // Synchronous-read pixel RAM
    logic [23:0] mem [0:(1<<AW)-1];
    logic [23:0] ram_q = 24'd0;
    always @(posedge clkIN) ram_q <= mem[pixelAddrOUT];
    assign pixelDataIN = ram_q;

    // Transmitter model: busy rises tx_delay edges after start is seen, lasts tx_len cycles
    int   tx_delay = 0;
    int   tx_len   = 10;
    int   tx_phase = 0;
    int   tx_cnt   = 0;
    logic model_busy = 1'b0;
    logic busy_force = 1'b0;
    assign txBusyIN = model_busy | busy_force;

    always @(posedge clkIN) begin
        case (tx_phase)
            0: if (txStartOUT === 1'b1) begin
                   if (tx_delay == 0) begin
                       model_busy <= 1'b1; tx_cnt <= tx_len - 1; tx_phase <= 2;
                   end else begin
                       tx_cnt <= tx_delay - 1; tx_phase <= 1;
                   end
               end
            1: if (tx_cnt == 0) begin
                   model_busy <= 1'b1; tx_cnt <= tx_len - 1; tx_phase <= 2;
               end else tx_cnt <= tx_cnt - 1;
            default: if (tx_cnt == 0) begin
                   model_busy <= 1'b0; tx_phase <= 0;
               end else tx_cnt <= tx_cnt - 1;
        endcase
    end

    // Monitor: handshakes, start-pulse widths, done pulses and busy-low run before done
    int   n_start = 0, n_done = 0, viol = 0, run_len = 0, low_run = 0, last_gap = 0;
    logic prev_start = 1'b0;
    logic [23:0]   q_data[$];
    logic [AW-1:0] q_addr[$];
    int            q_len[$];

    always @(negedge clkIN) begin
        if (txStartOUT === 1'b1 && !prev_start) begin
            n_start++;
            q_data.push_back(txDataOUT);
            q_addr.push_back(pixelAddrOUT);
            if (txBusyIN && !busy_force) viol++;
        end
        if (txStartOUT === 1'b1) run_len++;
        else if (run_len > 0) begin q_len.push_back(run_len); run_len = 0; end
        if (frameDoneOUT === 1'b1) begin n_done++; last_gap = low_run; end
        if (txBusyIN) low_run = 0; else low_run++;
        prev_start = (txStartOUT === 1'b1);
    end

    int total = 0, passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkIN);
        #1;
    endtask

    task automatic clear_mon();
        n_start = 0; n_done = 0; viol = 0; run_len = 0;
        q_data.delete(); q_addr.delete(); q_len.delete();
    endtask

    task automatic start_frame(input logic [7:0] b);
        brightnessIN = b; frameStartIN = 1'b1;
        tick(1);
        frameStartIN = 1'b0; brightnessIN = 8'h00;
    endtask

    // Returns at the falling edge inside the DONE cycle
    task automatic wait_done(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clkIN);
            if (frameDoneOUT === 1'b1) begin found = 1'b1; break; end
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_words(input string name, input logic [23:0] exp);
        check({name, "_count"}, q_data.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (q_data.size() > i) check($sformatf("%s_w%0d", name, i), q_data[i], exp);
    endtask

    typedef struct {
        logic [7:0]  bright;
        logic [23:0] word;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd255, 24'hFF8001, 24'hFF8001};
        vecs[1] = '{8'd127, 24'hFF8001, 24'h7F4000};
        vecs[2] = '{8'd0,   24'hFFFFFF, 24'h000000};
        vecs[3] = '{8'd128, 24'h102030, 24'h081018};
        vecs[4] = '{8'd1,   24'hFF80FF, 24'h010101};
        vecs[5] = '{8'd200, 24'h64C8FA, 24'h4E9DC4};
        for (int i = 0; i < (1 << AW); i++) mem[i] = 24'h0;

        // Reset with a start request held throughout
        resetIN = 1'b1; frameStartIN = 1'b1; brightnessIN = 8'hFF;
        tick(3);
        check("rst_busy", frameBusyOUT, 1'b0);
        check("rst_done", frameDoneOUT, 1'b0);
        check("rst_start", txStartOUT, 1'b0);
        check("rst_data", txDataOUT, 24'h0);
        check("rst_addr", pixelAddrOUT, 6'd0);
        resetIN = 1'b0; frameStartIN = 1'b0;
        clear_mon();
        tick(5);
        check("rst_start_ignored", frameBusyOUT, 1'b0);
        check("rst_no_handshake", n_start, 32'd0);

        // Full frame, identity brightness, long busy
        mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000AA;
        tx_delay = 0; tx_len = 1500;
        clear_mon();
        start_frame(8'd255);
        check("f1_busy_after_start", frameBusyOUT, 1'b1);
        check("f1_addr0", pixelAddrOUT, 6'd0);
        wait_done("f1");
        check("f1_busy_at_done", frameBusyOUT, 1'b0);
        tick(1);
        check("f1_done_len", frameDoneOUT, 1'b0);
        check("f1_starts", n_start, 32'd3);
        check("f1_done_pulses", n_done, 32'd1);
        check("f1_gap", last_gap, GAP + 1);
        check("f1_viol", viol, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (q_data.size() > i) check($sformatf("f1_data%0d", i), q_data[i], mem[i]);
            if (q_addr.size() > i) check($sformatf("f1_addr%0d", i), q_addr[i], i);
        end

        // Scaling vectors
        tx_len = 10;
        foreach (vecs[v]) begin
            for (int i = 0; i < PC; i++) mem[i] = vecs[v].word;
            clear_mon();
            start_frame(vecs[v].bright);
            wait_done($sformatf("scale%0d", v));
            tick(1);
            check_words($sformatf("scale%0d", v), vecs[v].exp);
        end

        // Start held for delayed busy: width = delay + 2 cycles
        mem[0] = 24'h123456; mem[1] = 24'h654321; mem[2] = 24'hABCDEF;
        tx_delay = 3; tx_len = 10;
        clear_mon();
        start_frame(8'd255);
        wait_done("hold");
        tick(1);
        check("hold_starts", n_start, 32'd3);
        check("hold_viol", viol, 32'd0);
        check("hold_widths", q_len.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (q_len.size() > i) check($sformatf("hold_w%0d", i), q_len[i], 32'd5);

        // Busy already high on entry to SEND
        tx_delay = 0; busy_force = 1'b1;
        clear_mon();
        start_frame(8'd255);
        tick(6);
        check("pre_busy_stuck_wait", n_done, 32'd0);
        busy_force = 1'b0;
        wait_done("pre_busy");
        tick(1);
        if (q_len.size() > 0) check("pre_busy_width", q_len[0], 32'd1);
        else check("pre_busy_width", 32'd0, 32'd1);
        check("pre_busy_done", n_done, 32'd1);

        // Mid-frame start ignored; start in DONE ignored
        clear_mon();
        start_frame(8'd255);
        tick(20);
        frameStartIN = 1'b1; tick(1); frameStartIN = 1'b0;
        wait_done("mid");
        frameStartIN = 1'b1;
        tick(1);
        frameStartIN = 1'b0;
        tick(3);
        check("done_start_ignored", frameBusyOUT, 1'b0);
        check("mid_starts", n_start, 32'd3);
        check("mid_done", n_done, 32'd1);

        // Back-to-back: start in the IDLE cycle right after DONE
        clear_mon();
        start_frame(8'd255);
        wait_done("b2b_a");
        @(posedge clkIN); #1;
        frameStartIN = 1'b1; tick(1); frameStartIN = 1'b0;
        check("b2b_busy", frameBusyOUT, 1'b1);
        check("b2b_addr0", pixelAddrOUT, 6'd0);
        wait_done("b2b_b");
        tick(1);
        check("b2b_starts", n_start, 32'd6);
        check("b2b_done", n_done, 32'd2);
        if (q_addr.size() > 3) check("b2b_first_addr", q_addr[3], 6'd0);
        else check("b2b_first_addr", 32'd0, 32'd1);

        // Reset during WAIT of the second pixel
        tx_len = 50;
        clear_mon();
        start_frame(8'd255);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clkIN); #1;
                if (n_start == 2 && txStartOUT == 1'b0 && txBusyIN == 1'b1) begin hit = 1'b1; break; end
            end
            if (!hit) check("abort_reach_wait", 32'd0, 32'd1);
        end
        resetIN = 1'b1;
        tick(1);
        check("abort_busy", frameBusyOUT, 1'b0);
        check("abort_done", frameDoneOUT, 1'b0);
        check("abort_start", txStartOUT, 1'b0);
        check("abort_data", txDataOUT, 24'h0);
        check("abort_addr", pixelAddrOUT, 6'd0);
        resetIN = 1'b0;
        tick(3500);
        check("abort_no_done", n_done, 32'd0);
        clear_mon();
        start_frame(8'd255);
        wait_done("after_abort");
        tick(1);
        check("after_abort_starts", n_start, 32'd3);
        check("after_abort_done", n_done, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
